// File: rtl/back_memory_writer.sv
// back_memory_writer: write-side controller for the background colour memory.
// Accepts single-pixel write commands over valid/ready. It can also clear the
// whole memory to CLEAR_COLOR. Only one write is outstanding at a time, and the
// next write starts only after the memory acknowledge (or an ack timeout).
module back_memory_writer #(
  parameter int unsigned        ADDR_W      = 13,
  parameter int unsigned        DATA_W      = 9,
  parameter int unsigned        MEM_DEPTH   = 4800,
  parameter logic [DATA_W-1:0]  CLEAR_COLOR = '0,
  parameter int unsigned        ACK_TIMEOUT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              start_clear,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic              mem_ack,
  output logic              busy,
  output logic              clear_done,
  output logic              err_addr,
  output logic              err_timeout
);

  localparam int unsigned        TMO_W     = $clog2(ACK_TIMEOUT + 1);
  localparam logic [ADDR_W:0]    DEPTH_X   = (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [TMO_W-1:0]   TMO_LIMIT = TMO_W'(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WAIT_ACK,
    CLR_WRITE,
    CLR_WAIT
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [ADDR_W-1:0] mem_address_q;
  logic [DATA_W-1:0] mem_data_q;
  logic              mem_wren_q;
  logic              busy_q;
  logic              clear_done_q;
  logic              err_addr_q;
  logic              err_timeout_q;

  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign mem_wren    = mem_wren_q;
  assign busy        = busy_q;
  assign clear_done  = clear_done_q;
  assign err_addr    = err_addr_q;
  assign err_timeout = err_timeout_q;

  // Combinational handshake: a pending clear request blocks command acceptance.
  assign cmd_ready = (state_q == IDLE) && !start_clear;

  // Incremented values of the clear and ack-timeout counters.
  always_comb begin
    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
    tmo_d     = tmo_q + TMO_W'(1);
  end

  // Main FSM with registered memory-side outputs and status pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      clr_cnt_q     <= '0;
      tmo_q         <= '0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_wren_q    <= 1'b0;
      busy_q        <= 1'b0;
      clear_done_q  <= 1'b0;
      err_addr_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      mem_wren_q    <= 1'b0;
      clear_done_q  <= 1'b0;
      err_addr_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (start_clear) begin
            clr_cnt_q     <= '0;
            mem_address_q <= '0;
            mem_data_q    <= CLEAR_COLOR;
            mem_wren_q    <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= CLR_WRITE;
          end else if (cmd_valid) begin
            if ({1'b0, cmd_address} >= DEPTH_X) begin
              err_addr_q <= 1'b1;
            end else begin
              mem_address_q <= cmd_address;
              mem_data_q    <= cmd_data;
              mem_wren_q    <= 1'b1;
              busy_q        <= 1'b1;
              state_q       <= WRITE;
            end
          end
        end
        WRITE: begin
          tmo_q   <= '0;
          state_q <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (mem_ack) begin
            tmo_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (tmo_d == TMO_LIMIT) begin
            tmo_q         <= '0;
            err_timeout_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        CLR_WRITE: begin
          tmo_q   <= '0;
          state_q <= CLR_WAIT;
        end
        CLR_WAIT: begin
          if (mem_ack) begin
            tmo_q <= '0;
            if (clr_cnt_q == LAST_ADDR) begin
              clear_done_q <= 1'b1;
              busy_q       <= 1'b0;
              state_q      <= IDLE;
            end else begin
              clr_cnt_q     <= clr_cnt_d;
              mem_address_q <= clr_cnt_d;
              mem_data_q    <= CLEAR_COLOR;
              mem_wren_q    <= 1'b1;
              state_q       <= CLR_WRITE;
            end
          end else if (tmo_d == TMO_LIMIT) begin
            tmo_q         <= '0;
            err_timeout_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_back_memory_writer.sv
// Self-checking bench for back_memory_writer: a behavioural memory that acks
// one cycle after each write, plus an expected-contents array updated from
// the command stream.
module tb_back_memory_writer;

  localparam int DEPTH = 4800;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [12:0] cmd_address = '0;
  logic [8:0]  cmd_data = '0;
  logic        start_clear = 1'b0;
  logic [12:0] mem_address;
  logic [8:0]  mem_data;
  logic        mem_wren;
  logic        mem_ack = 1'b0;
  logic        busy, clear_done, err_addr, err_timeout;

  back_memory_writer #(
    .ADDR_W(13), .DATA_W(9), .MEM_DEPTH(DEPTH), .CLEAR_COLOR(9'd0), .ACK_TIMEOUT(4)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_address(cmd_address), .cmd_data(cmd_data),
    .start_clear(start_clear),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_ack(mem_ack),
    .busy(busy), .clear_done(clear_done),
    .err_addr(err_addr), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int failed = 0;

  // Memory model and event counters
  logic [8:0] mem     [0:8191];
  logic [8:0] ref_mem [0:8191];
  logic       ack_en = 1'b1;
  logic       prev_wren = 1'b0;
  int         wren_b2b = 0;
  int         done_cnt = 0;
  int         wren_cnt = 0;
  int unsigned cyc = 0;

  always @(posedge clock) begin
    cyc = cyc + 1;
    if (mem_wren) begin
      mem[mem_address] = mem_data;
      wren_cnt = wren_cnt + 1;
      if (prev_wren) wren_b2b = wren_b2b + 1;
    end
    if (clear_done) done_cnt = done_cnt + 1;
    prev_wren = mem_wren;
    mem_ack <= mem_wren && ack_en;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int mismatches();
    int n = 0;
    for (int i = 0; i < DEPTH; i++)
      if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  task automatic wait_ready();
    int k = 0;
    while (!cmd_ready && k < 50) begin
      step();
      k++;
    end
    check("ready_wait", {31'd0, cmd_ready}, 32'd1);
  endtask

  // One full command: acceptance, single-cycle write, ready again three cycles on.
  int unsigned acc_cyc;
  task automatic write_cmd(input logic [12:0] a, input logic [8:0] d, input bit hold);
    cmd_address = a;
    cmd_data    = d;
    cmd_valid   = 1'b1;
    wait_ready();
    step();
    acc_cyc = cyc;
    if (!hold) cmd_valid = 1'b0;
    check("wr_wren", {31'd0, mem_wren}, 32'd1);
    check("wr_addr", {19'd0, mem_address}, {19'd0, a});
    check("wr_data", {23'd0, mem_data}, {23'd0, d});
    check("wr_busy", {31'd0, busy}, 32'd1);
    check("wr_notready", {31'd0, cmd_ready}, 32'd0);
    step();
    check("wr_wren_one", {31'd0, mem_wren}, 32'd0);
    step();
    check("wr_ready_n3", {31'd0, cmd_ready}, 32'd1);
    check("wr_idle", {31'd0, busy}, 32'd0);
    ref_mem[a] = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int unsigned c0, c1, c2;
    int k, d0;
    logic [12:0] ha;
    logic [8:0]  hd;

    for (int i = 0; i < 8192; i++) begin
      mem[i] = 9'd0;
      ref_mem[i] = 9'd0;
    end

    // Reset state
    repeat (3) step();
    check("rst_wren", {31'd0, mem_wren}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_addr", {19'd0, mem_address}, 32'd0);
    check("rst_flags", {29'd0, clear_done, err_addr, err_timeout}, 32'd0);
    reset = 1'b1;
    step();
    check("idle_ready", {31'd0, cmd_ready}, 32'd1);

    // Single write
    write_cmd(13'd100, 9'h1C7, 1'b0);
    step();
    check("mem100", {23'd0, mem[100]}, 32'h1C7);

    // Back-to-back with valid held
    write_cmd(13'd0, 9'h011, 1'b1); c0 = acc_cyc;
    write_cmd(13'd1, 9'h022, 1'b1); c1 = acc_cyc;
    write_cmd(13'd2, 9'h033, 1'b0); c2 = acc_cyc;
    check("b2b_gap1", c1 - c0, 32'd3);
    check("b2b_gap2", c2 - c1, 32'd3);

    // Random in-range writes
    for (int i = 0; i < 12; i++) begin
      r = $urandom;
      write_cmd(13'($urandom_range(0, DEPTH - 1)), r[8:0], r[9]);
    end
    cmd_valid = 1'b0;

    // Out-of-range addresses: boundary then random
    for (int i = 0; i < 4; i++) begin
      k = wren_cnt;
      cmd_address = (i == 0) ? 13'd4800 : 13'($urandom_range(DEPTH, 8191));
      cmd_data    = 9'h1FF;
      cmd_valid   = 1'b1;
      step();
      cmd_valid = 1'b0;
      check("oor_err", {31'd0, err_addr}, 32'd1);
      check("oor_busy", {31'd0, busy}, 32'd0);
      step();
      check("oor_pulse", {31'd0, err_addr}, 32'd0);
      check("oor_nowrite", wren_cnt - k, 32'd0);
    end
    write_cmd(13'd4799, 9'h155, 1'b0);
    step();
    check("mem_contents_a", mismatches(), 32'd0);

    // Ack withheld: timeout four cycles after entering the ack wait
    ack_en = 1'b0;
    cmd_address = 13'd77; cmd_data = 9'h0AA; cmd_valid = 1'b1;
    wait_ready();
    step();
    cmd_valid = 1'b0;
    ref_mem[77] = 9'h0AA;
    k = 0;
    while (!err_timeout && k < 20) begin
      step();
      k++;
    end
    check("tmo_latency", k, 32'd5);
    check("tmo_busy", {31'd0, busy}, 32'd0);
    check("tmo_ready", {31'd0, cmd_ready}, 32'd1);
    step();
    check("tmo_pulse", {31'd0, err_timeout}, 32'd0);
    ack_en = 1'b1;
    write_cmd(13'd78, 9'h0BB, 1'b0);

    // Clear with simultaneous command
    for (int i = 0; i < DEPTH; i++) begin
      r = $urandom;
      mem[i] = r[8:0];
      ref_mem[i] = r[8:0];
    end
    ha = 13'd321; hd = 9'h0F0;
    d0 = done_cnt;
    cmd_address = ha; cmd_data = hd; cmd_valid = 1'b1; start_clear = 1'b1;
    #1;
    check("clr_blocks_ready", {31'd0, cmd_ready}, 32'd0);
    step();
    start_clear = 1'b0;
    check("clr_first_wren", {31'd0, mem_wren}, 32'd1);
    check("clr_first_addr", {19'd0, mem_address}, 32'd0);
    check("clr_first_data", {23'd0, mem_data}, 32'd0);
    check("clr_busy", {31'd0, busy}, 32'd1);
    k = 0;
    while (!clear_done && k < 9700) begin
      step();
      k++;
    end
    check("clr_latency", k, 32'd9600);
    check("clr_done_idle", {31'd0, busy}, 32'd0);
    check("clr_held_ready", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
    check("held_wren", {31'd0, mem_wren}, 32'd1);
    check("held_addr", {19'd0, mem_address}, {19'd0, ha});
    check("held_data", {23'd0, mem_data}, {23'd0, hd});
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 9'd0;
    ref_mem[ha] = hd;
    repeat (5) step();
    check("clr_done_once", done_cnt - d0, 32'd1);
    check("mem_contents_clr", mismatches(), 32'd0);

    // Reset mid-clear at word 2000
    for (int i = 0; i < DEPTH; i++) begin
      r = $urandom;
      mem[i] = r[8:0];
      ref_mem[i] = r[8:0];
    end
    d0 = done_cnt;
    start_clear = 1'b1;
    step();
    start_clear = 1'b0;
    k = 0;
    while (!(mem_wren && mem_address == 13'd2000) && k < 5000) begin
      step();
      k++;
    end
    check("reach_2000", {19'd0, mem_address}, 32'd2000);
    reset = 1'b0;
    #1;
    check("rst_mid_wren", {31'd0, mem_wren}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_addr", {19'd0, mem_address}, 32'd0);
    for (int i = 0; i < 2000; i++) ref_mem[i] = 9'd0;
    repeat (3) step();
    reset = 1'b1;
    repeat (10) step();
    check("rst_no_done", done_cnt - d0, 32'd0);
    check("mem_contents_abort", mismatches(), 32'd0);

    start_clear = 1'b1;
    step();
    start_clear = 1'b0;
    check("restart_addr", {19'd0, mem_address}, 32'd0);
    check("restart_wren", {31'd0, mem_wren}, 32'd1);
    k = 0;
    while (!clear_done && k < 9700) begin
      step();
      k++;
    end
    check("restart_latency", k, 32'd9600);
    step();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 9'd0;
    check("mem_contents_final", mismatches(), 32'd0);
    check("wren_never_b2b", wren_b2b, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
